// File: rtl/trace_pkg.sv
// Shared definitions for the observation trace recorder.
//   - recorder FSM state encoding
//   - entry kind codes
//   - entry layout helpers: {cycle, kind, data} with data in the low bits
//   - drop counter width and saturation value
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FROZEN = 2'd2
  } state_t;

  localparam logic KIND_OBS  = 1'b1;
  localparam logic KIND_DISP = 1'b0;

  localparam int                DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic int entry_width(input int data_w, input int cyc_w);
    return cyc_w + 1 + data_w;
  endfunction

  // Kind bit sits directly above the data word.
  function automatic int kind_lsb(input int data_w);
    return data_w;
  endfunction

  // Cycle stamp occupies the top of the entry.
  function automatic int cyc_lsb(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular entry buffer for the trace recorder.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_push, i_entry : write request and entry; dropped if full without a pop
//   i_rd_ready      : consumer accepts the head entry
//   o_valid, o_entry: head entry available / head entry (0 when empty)
//   o_count         : entries held (0..DEPTH)
//   o_full          : count == DEPTH
// Writes are registered; an empty buffer never bypasses to the read side.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int ENTRY_W = 49,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_entry,
  input  logic               i_rd_ready,
  output logic               o_valid,
  output logic [ENTRY_W-1:0] o_entry,
  output logic [ADDR_W:0]    o_count,
  output logic               o_full
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_count;

  logic w_pop;
  logic w_push_ok;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_entry = o_valid ? r_mem[r_rd_ptr] : '0;

  assign w_pop     = o_valid && i_rd_ready;
  // A full buffer can still take a write when the head leaves on the same edge.
  assign w_push_ok = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/obs_trace_recorder.sv
// Observation trace recorder: samples the DUT output alongside the
// driver's obs / sig_display flags and stores qualifying events as
// timestamped entries {cycle, kind, data} for readback over valid/ready.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   arm, stop         : start/restart and freeze recording (pulses)
//   obs, sig_display  : driver per-step flags
//   out_data          : DUT output for this cycle
//   rd_valid/rd_ready : entry read handshake; rd_entry is the head entry
//   count             : entries held
//   overflow          : sticky, an event was dropped on a full buffer
//   drop_cnt          : dropped events, saturating at 255
//   done              : frozen and fully drained
//
// state  | meaning
// IDLE   | after reset, waiting for the first arm
// RECORD | timestamping and capturing events
// FROZEN | no capture; consumer drains; arm on empty restarts
module obs_trace_recorder
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CYC_W  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    stop,
  input  logic                    obs,
  input  logic                    sig_display,
  input  logic [DATA_W-1:0]       out_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [CYC_W+DATA_W:0]   rd_entry,
  output logic [ADDR_W:0]         count,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_cnt,
  output logic                    done
);

  localparam int ENTRY_W  = entry_width(DATA_W, CYC_W);
  localparam int KIND_LSB = kind_lsb(DATA_W);
  localparam int CYC_LSB  = cyc_lsb(DATA_W);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start;

  logic [CYC_W-1:0]    r_cycle;
  logic [DATA_W-1:0]   r_last_out;
  logic                r_overflow;
  logic [DROP_W-1:0]   r_drop_cnt;

  logic                w_recording;
  logic                w_event;
  logic                w_kind;
  logic                w_pop;
  logic                w_full;
  logic                w_push;
  logic                w_drop;
  logic [ENTRY_W-1:0]  w_entry;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state; w_start marks an edge that (re)starts a recording.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_state_nxt = RECORD;
          w_start     = 1'b1;
        end
      end
      RECORD: begin
        // arm is meaningless while recording, so stop always wins.
        if (stop) w_state_nxt = FROZEN;
      end
      FROZEN: begin
        // Restart only once the previous trace has been fully drained.
        if (arm && (count == '0)) begin
          w_state_nxt = RECORD;
          w_start     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Event qualification on this cycle's inputs
  assign w_recording = (r_state == RECORD);
  assign w_kind      = obs ? KIND_OBS : KIND_DISP;
  assign w_event     = w_recording && (obs || (sig_display && (out_data != r_last_out)));

  assign w_pop  = rd_valid && rd_ready;
  assign w_push = w_event && (!w_full || w_pop);
  assign w_drop = w_event && w_full && !w_pop;

  always_comb begin
    w_entry                        = '0;
    w_entry[DATA_W-1:0]            = out_data;
    w_entry[KIND_LSB]              = w_kind;
    w_entry[CYC_LSB +: CYC_W]      = r_cycle;
  end

  // Timestamp, change-detect history and drop accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle    <= '0;
      r_last_out <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_start) begin
      r_cycle    <= '0;
      r_last_out <= out_data;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_recording) begin
      r_cycle    <= r_cycle + 1'b1;
      r_last_out <= out_data;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != DROP_MAX) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  trace_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_fifo (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_push     (w_push),
    .i_entry    (w_entry),
    .i_rd_ready (rd_ready),
    .o_valid    (rd_valid),
    .o_entry    (rd_entry),
    .o_count    (count),
    .o_full     (w_full)
  );

  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;
  assign done     = (r_state == FROZEN) && (count == '0);

endmodule

// File: tb/tb_obs_trace_recorder.sv
module tb_obs_trace_recorder;

  localparam int DATA_W  = 32;
  localparam int CYC_W   = 16;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int ENTRY_W = CYC_W + 1 + DATA_W;

  logic                clk = 1'b0;
  logic                reset, arm, stop, obs, sig_display, rd_ready;
  logic [DATA_W-1:0]   out_data;
  logic                rd_valid, overflow, done;
  logic [ENTRY_W-1:0]  rd_entry;
  logic [ADDR_W:0]     count;
  logic [7:0]          drop_cnt;

  always #5 clk = ~clk;

  obs_trace_recorder #(
    .DATA_W (DATA_W),
    .CYC_W  (CYC_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .stop        (stop),
    .obs         (obs),
    .sig_display (sig_display),
    .out_data    (out_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_entry    (rd_entry),
    .count       (count),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .done        (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: the trace is a queue; recorder mode is a small integer.
  localparam int M_IDLE = 0, M_REC = 1, M_FRZ = 2;
  logic [ENTRY_W-1:0] m_q[$];
  int                 m_mode;
  logic [CYC_W-1:0]   m_cyc;
  logic [DATA_W-1:0]  m_last;
  bit                 m_ovf;
  int                 m_drop;

  function automatic void model_reset();
    m_q.delete();
    m_mode = M_IDLE;
    m_cyc  = '0;
    m_last = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endfunction

  function automatic void model_advance(bit r, bit a, bit s, bit o, bit d,
                                        logic [DATA_W-1:0] od, bit rr);
    int n_pre;
    bit pop, ev;
    if (r) begin
      model_reset();
      return;
    end
    n_pre = m_q.size();
    pop   = (n_pre != 0) && rr;
    ev    = (m_mode == M_REC) && (o || (d && (od != m_last)));
    if (pop) void'(m_q.pop_front());
    if (ev) begin
      if (n_pre < DEPTH || pop) m_q.push_back({m_cyc, o, od});
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    case (m_mode)
      M_IDLE: if (a) begin m_mode = M_REC; m_cyc = '0; m_last = od; end
      M_REC: begin
        m_cyc  = m_cyc + 1'b1;
        m_last = od;
        if (s) m_mode = M_FRZ;
      end
      default: if (a && n_pre == 0) begin
        m_mode = M_REC; m_cyc = '0; m_last = od; m_ovf = 1'b0; m_drop = 0;
      end
    endcase
  endfunction

  task automatic check_outputs();
    int n;
    n = m_q.size();
    chk("count", 64'(count), 64'(n));
    chk("rd_valid", 64'(rd_valid), 64'(n != 0));
    if (n != 0) chk("rd_entry", 64'(rd_entry), 64'(m_q[0]));
    else        chk("rd_entry_empty", 64'(rd_entry), 64'd0);
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("done", 64'(done), 64'((m_mode == M_FRZ) && (n == 0)));
  endtask

  // One clock: drive at posedge+1, compare at negedge, then advance the model.
  task automatic step(input bit r, input bit a, input bit s, input bit o, input bit d,
                      input logic [DATA_W-1:0] od, input bit rr);
    reset = r; arm = a; stop = s; obs = o; sig_display = d; out_data = od; rd_ready = rr;
    @(negedge clk);
    check_outputs();
    model_advance(r, a, s, o, d, od, rr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input bit rr);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, rr);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  logic [ENTRY_W-1:0] exp_e;
  logic [CYC_W-1:0]   head_cyc;

  initial begin
    reset = 1'b1; arm = 1'b0; stop = 1'b0; obs = 1'b0;
    sig_display = 1'b0; out_data = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // Obs events at cycles 0, 2, 3
    do_reset();
    step(0, 1, 0, 0, 0, 32'd0, 0);
    step(0, 0, 0, 1, 0, 32'd5, 0);
    idle_step(0);
    step(0, 0, 0, 1, 0, 32'd7, 0);
    step(0, 0, 0, 1, 0, 32'd9, 0);
    chk("s1_count", 64'(count), 64'd3);
    exp_e = {16'd0, 1'b1, 32'd5};
    chk("s1_e0", 64'(rd_entry), 64'(exp_e));
    idle_step(1);
    exp_e = {16'd2, 1'b1, 32'd7};
    chk("s1_e1", 64'(rd_entry), 64'(exp_e));
    idle_step(1);
    exp_e = {16'd3, 1'b1, 32'd9};
    chk("s1_e2", 64'(rd_entry), 64'(exp_e));
    idle_step(1);
    chk("s1_empty", 64'(rd_valid), 64'd0);

    // Display change detection
    do_reset();
    step(0, 1, 0, 0, 0, 32'd4, 0);
    step(0, 0, 0, 0, 1, 32'd4, 0);
    step(0, 0, 0, 0, 1, 32'd4, 0);
    step(0, 0, 0, 0, 1, 32'd6, 0);
    step(0, 0, 0, 0, 1, 32'd6, 0);
    chk("s2_count", 64'(count), 64'd1);
    exp_e = {16'd2, 1'b0, 32'd6};
    chk("s2_entry", 64'(rd_entry), 64'(exp_e));

    // Overflow, then full with simultaneous pop
    do_reset();
    step(0, 1, 0, 0, 0, 32'd0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 32'(100 + i), 0);
    chk("s3_count", 64'(count), 64'd16);
    chk("s3_overflow", 64'(overflow), 64'd1);
    chk("s3_drop", 64'(drop_cnt), 64'd4);
    head_cyc = rd_entry[ENTRY_W-1 -: CYC_W];
    chk("s3_first_cyc", 64'(head_cyc), 64'd0);
    step(0, 0, 0, 1, 0, 32'hABCD, 1);
    chk("s4_count", 64'(count), 64'd16);
    chk("s4_drop", 64'(drop_cnt), 64'd4);
    for (int i = 0; i < 16; i++) idle_step(1);
    chk("s4_drained", 64'(count), 64'd0);

    // Stop, drain, re-arm
    do_reset();
    step(0, 1, 0, 0, 0, 32'd0, 0);
    step(0, 0, 0, 1, 0, 32'd1, 0);
    step(0, 0, 0, 1, 0, 32'd2, 0);
    step(0, 0, 1, 0, 0, 32'd0, 0);
    chk("s5_done_held", 64'(done), 64'd0);
    chk("s5_count", 64'(count), 64'd2);
    idle_step(1);
    idle_step(1);
    chk("s5_done", 64'(done), 64'd1);
    step(0, 1, 0, 0, 0, 32'd0, 0);
    chk("s5_rearm_done", 64'(done), 64'd0);
    chk("s5_rearm_ovf", 64'(overflow), 64'd0);
    step(0, 0, 0, 1, 0, 32'd77, 0);
    exp_e = {16'd0, 1'b1, 32'd77};
    chk("s5_rearm_entry", 64'(rd_entry), 64'(exp_e));

    // Reset mid-record, then arm+stop together
    do_reset();
    step(0, 1, 0, 0, 0, 32'd0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 32'(i), 0);
    chk("s6_count5", 64'(count), 64'd5);
    do_reset();
    chk("s6_count0", 64'(count), 64'd0);
    chk("s6_valid0", 64'(rd_valid), 64'd0);
    step(0, 0, 0, 1, 0, 32'd3, 0);
    chk("s6_idle_no_rec", 64'(count), 64'd0);
    step(0, 1, 0, 0, 0, 32'd0, 0);
    step(0, 1, 1, 0, 0, 32'd0, 0);
    chk("s6_frozen", 64'(done), 64'd1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 1) == 1),
           32'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 4));
    end
    idle_step(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obs_trace_recorder.md
Name: obs_trace_recorder

Overview:
- Downstream consumer of the concolic stimulus driver and DUT pair.
- Samples the DUT output each cycle, together with the driver's per-step obs and sig_display flags.
- Records qualifying events as timestamped entries in a circular buffer.
- The harness reads entries back through a valid/ready port, so solver-side trace extraction does not depend on $strobe text.

Parameters:
- DATA_W, 32, width of DUT out / stimulus word
- CYC_W, 16, width of cycle timestamp in each entry
- DEPTH, 16, buffer entries (power of two, >=2)
- ADDR_W, $clog2(DEPTH), derived pointer width

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- arm  input  1  pulse: start or restart recording
- stop  input  1  pulse: freeze recording
- obs  input  1  driver observation flag (opcode bit 33)
- sig_display  input  1  driver display flag (opcode bit 32)
- out_data  input  DATA_W  DUT output sampled this cycle
- rd_valid  output  1  entry available
- rd_ready  input  1  consumer accepts entry
- rd_entry  output  CYC_W+1+DATA_W  {cycle, kind, data}
- count  output  ADDR_W+1  entries held
- overflow  output  1  sticky: at least one entry dropped
- drop_cnt  output  8  dropped entries, saturates at 255
- done  output  1  FROZEN and buffer empty

Behaviour:
- Reset values: all outputs 0, state IDLE, pointers 0, cycle 0, last_out 0.
- States:
  - IDLE: arm -> RECORD; cycle=0, last_out=out_data.
  - RECORD: cycle increments by 1 each clk and wraps modulo 2^CYC_W. stop -> FROZEN. If arm and stop are both high, stop wins.
  - FROZEN: no writes; reads continue. arm while count==0 -> RECORD, clearing cycle, overflow and drop_cnt. arm while count!=0 is ignored.
- Event qualification, RECORD only, evaluated on the current-cycle inputs:
  - obs=1 -> kind=1, data=out_data.
  - Otherwise, sig_display=1 and out_data!=last_out -> kind=0, data=out_data.
  - Otherwise no entry.
  - last_out updates to out_data every RECORD cycle.
- Entry cycle field is the pre-increment cycle value of the sampling edge.
- Write latency: an event sampled at edge N is visible on rd_valid/rd_entry after edge N, i.e. registered with 1-cycle latency.
- Read: pop when rd_valid && rd_ready. rd_entry is the head entry, stable while rd_valid=1 and rd_ready=0.
- Full (count==DEPTH) with no pop that cycle: event is dropped, overflow<=1, drop_cnt increments with saturation.
- Full with a simultaneous pop: write is accepted and count is unchanged.
- Empty with a simultaneous write: no bypass; rd_valid rises the next cycle.
- Pointers wrap modulo DEPTH.
- done = (state==FROZEN) && count==0, registered-state combinational.
- reset mid-operation discards buffer contents and returns to IDLE.

Decomposition:
- Shared package trace_pkg holds:
  - state enum {IDLE, RECORD, FROZEN}
  - KIND_OBS=1, KIND_DISP=0
  - entry field offsets/widths
- One sub-module, trace_fifo: storage, pointers, count, valid/ready read side, with a full flag exported.
- FSM, event qualification, timestamps and overflow accounting live in the top.

Test Plan:
- Reset then arm. obs=1 at cycles 0,2,3 with out_data=5,7,9, rd_ready=0 -> count=3. Entries read back as {0,1,5},{2,1,7},{3,1,9}.
- sig_display=1, obs=0, out_data 4,4,6,6 from cycle 0 with last_out=4 at arm -> single entry {2,0,6}.
- obs=1 for 20 cycles, DEPTH=16, rd_ready=0 -> count=16, overflow=1, drop_cnt=4. First entry read has cycle 0.
- Buffer full with rd_ready=1 and obs=1 at the same edge -> count stays 16, no drop, newest entry is written at the tail.
- stop with 2 entries held -> FROZEN, done=0. Drain 2 entries -> done=1. arm -> RECORD with cycle=0, overflow=0.
- Assert reset while in RECORD with 5 entries held -> next cycle count=0, rd_valid=0, state IDLE. arm+stop in the same cycle from RECORD -> FROZEN.
